// File: rtl/wide_add_pkg.sv
// Shared definitions for the sequential wide adder: FSM state encoding and default sizing.
package wide_add_pkg;

  localparam int W_DEF  = 20;
  localparam int NS_DEF = 4;
  localparam int CW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wide_add_seq_add_slice.sv
// Combinational W-bit adder slice with carry in and carry out.
module add_slice #(
  parameter int W = 20
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  // Zero-extend by one bit so the MSB of the result is the carry.
  assign full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle (W*NS)-bit adder that sequences one add_slice LSB-first with a registered carry.
// Optional subtract mode (extra port sub) is enabled by defining WIDE_ADD_SEQ_SUB_EN.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NS = NS_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W*NS-1:0] a,
  input  logic [W*NS-1:0] b,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic            sub,
`endif
  input  logic            ci,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W*NS-1:0] s,
  output logic            co
);

  localparam int TW = W * NS;
  localparam int NE = 1 << CW;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            carry_reg;
  logic [TW-1:0]   a_reg;
  logic [TW-1:0]   b_reg;

  logic [W-1:0]    a_sl [NE];
  logic [W-1:0]    b_sl [NE];
  logic [W-1:0]    slice_x;
  logic [W-1:0]    slice_y;
  logic [W-1:0]    slice_sum;
  logic            slice_cout;

  logic [TW-1:0]   b_load;
  logic            carry_load;

  // Slice views sized to the full counter range so any counter value indexes safely.
  genvar gi;
  generate
    for (gi = 0; gi < NE; gi++) begin : g_slice_view
      if (gi < NS) begin : g_used
        assign a_sl[gi] = a_reg[gi*W +: W];
        assign b_sl[gi] = b_reg[gi*W +: W];
      end else begin : g_unused
        assign a_sl[gi] = '0;
        assign b_sl[gi] = '0;
      end
    end
  endgenerate

  assign slice_x = a_sl[cnt_reg];
  assign slice_y = b_sl[cnt_reg];

  add_slice #(.W(W)) u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

`ifdef WIDE_ADD_SEQ_SUB_EN
  // Subtract as a + ~b + 1; the final carry then reads as "no borrow".
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : ci;
`else
  assign b_load     = b;
  assign carry_load = ci;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s         <= '0;
      co        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b_load;
            carry_reg <= carry_load;
            cnt_reg   <= '0;
            s         <= '0;
            co        <= 1'b0;
            in_ready  <= 1'b0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NS; k++) begin
            if (cnt_reg == CW'(k)) begin
              s[k*W +: W] <= slice_sum;
            end
          end
          carry_reg <= slice_cout;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(NS - 1)) begin
            co        <= slice_cout;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized and directed bench for wide_add_seq against an arithmetic reference model.
module tb_wide_add_seq;

  localparam int W  = 20;
  localparam int NS = 4;
  localparam int CW = 3;
  localparam int TW = W * NS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          ci = 1'b0;
  logic [TW-1:0] a = '0;
  logic [TW-1:0] b = '0;
`ifdef WIDE_ADD_SEQ_SUB_EN
  logic          sub = 1'b0;
`endif
  logic          in_ready;
  logic          out_valid;
  logic [TW-1:0] s;
  logic          co;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.W(W), .NS(NS), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
  );

  task automatic check(input string tag, input logic [TW:0] got, input logic [TW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: the whole operation as one wide arithmetic expression.
  function automatic logic [TW:0] model(input logic [TW-1:0] x, input logic [TW-1:0] y,
                                        input logic c, input logic sb);
    logic [TW:0] r;
    if (sb) begin
      r[TW-1:0] = x - y;
      r[TW]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{TW{1'b0}}, c};
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] rand_wide();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 5))
      0: t = '1;
      1: t = '0;
      default: ;
    endcase
    return t[TW-1:0];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {TW+1{1'b0}}, {{TW{1'b0}}, 1'b1});
  endtask

  task automatic run_op(input logic [TW-1:0] x, input logic [TW-1:0] y, input logic c,
                        input logic sb, input int hold, input string tag);
    logic [TW:0] exp;
    int lat;
    wait_ready();
    a = x;
    b = y;
    ci = c;
`ifdef WIDE_ADD_SEQ_SUB_EN
    sub = sb;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_s_cleared"}, {1'b0, s}, '0);
    check({tag, "_busy"}, {{TW{1'b0}}, in_ready}, '0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, (TW+1)'(lat), (TW+1)'(NS));
    exp = model(x, y, c, sb);
    check({tag, "_sum"}, {1'b0, s}, {1'b0, exp[TW-1:0]});
    check({tag, "_co"}, {{TW{1'b0}}, co}, {{TW{1'b0}}, exp[TW]});
    // Backpressure: junk operands offered while the result is held must be ignored.
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = ~x;
      b = x;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_s"}, {co, s}, exp);
      check({tag, "_hold_valid"}, {{TW{1'b0}}, out_valid}, {{TW{1'b0}}, 1'b1});
      check({tag, "_hold_ready"}, {{TW{1'b0}}, in_ready}, '0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, {{TW{1'b0}}, out_valid}, '0);
    check({tag, "_drain_ready"}, {{TW{1'b0}}, in_ready}, {{TW{1'b0}}, 1'b1});
    $display("op %s a=%h b=%h ci=%0d sub=%0d -> s=%h co=%0d lat=%0d", tag, x, y, c, sb,
             exp[TW-1:0], exp[TW], lat);
  endtask

  initial begin
    logic [TW-1:0] ones;
    logic [TW-1:0] v;
    ones = '1;

    #12;
    check("rst_in_ready", {{TW{1'b0}}, in_ready}, {{TW{1'b0}}, 1'b1});
    check("rst_out_valid", {{TW{1'b0}}, out_valid}, '0);
    check("rst_s_co", {co, s}, '0);
    @(negedge clk);
    rst = 1'b0;

    run_op(80'h1, 80'h2, 1'b0, 1'b0, 0, "basic");
    v = 80'h00000_00000_00000_FFFFF;
    run_op(v, 80'h1, 1'b0, 1'b0, 0, "xslice");
    run_op(ones, '0, 1'b1, 1'b0, 0, "wrap0");
    run_op(ones, ones, 1'b1, 1'b0, 0, "wrap1");
    run_op(80'h12345_6789A_BCDEF_13579, 80'hFEDCB_A9876_54321_02468, 1'b0, 1'b0, 10, "bp");
    run_op(80'h3, 80'h4, 1'b1, 1'b0, 0, "after_bp");

    // Reset after two slices have completed: everything must clear immediately.
    wait_ready();
    a = ones;
    b = ones;
    ci = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_out_valid", {{TW{1'b0}}, out_valid}, '0);
    check("midrun_s_co", {co, s}, '0);
    check("midrun_in_ready", {{TW{1'b0}}, in_ready}, {{TW{1'b0}}, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    run_op(80'd5, 80'd7, 1'b0, 1'b0, 0, "post_rst");

    for (int i = 0; i < 20; i++) begin
      run_op(rand_wide(), rand_wide(), 1'($urandom), 1'b0, $urandom_range(0, 3), "rand");
    end

`ifdef WIDE_ADD_SEQ_SUB_EN
    run_op(80'd10, 80'd3, 1'b0, 1'b1, 0, "sub_pos");
    run_op(80'd3, 80'd10, 1'b1, 1'b1, 0, "sub_neg");
    for (int i = 0; i < 10; i++) begin
      run_op(rand_wide(), rand_wide(), 1'($urandom), 1'($urandom), $urandom_range(0, 2), "rand_sub");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
